player_motion_ctrl: RTL

//  Per-frame player physics/camera controller; sits upstream of the pixel/collision renderer.

---
 rtl/player_motion_ctrl_pkg.sv | 31 +++
 rtl/player_motion_ctrl_if.sv | 33 +++
 rtl/player_motion_ctrl_btn_sync.sv | 27 ++
 rtl/player_motion_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/player_motion_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared geometry constants and state encodings for the player
//            motion controller and its renderer-facing interface.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int SCREEN_W  = 1440;
  localparam int MAP_H     = 864;
  localparam int PLAYER_SZ = 48;
  localparam int TILE      = 16;

  // Per-frame sequencer states; DONE is terminal until reset.
  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_RESOLVE = 3'd1,
    ST_MOVE    = 3'd2,
    ST_ACK     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Axis handled by the next MOVE step.
  typedef enum logic {
    PH_X = 1'b0,
    PH_Y = 1'b1
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/player_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : player_motion_ctrl_if
// Brief    : Bundle between the game/renderer side and the motion controller.
//            master = renderer/frame timing side, slave = motion controller.
// Revision : 1.0 - initial release
// ============================================================================
interface player_motion_ctrl_if;
  logic        frame_tick;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic        col_detected;
  logic        outbounds;
  logic        game_win;
  logic [10:0] blkpos_x;
  logic [9:0]  blkpos_y;
  logic [11:0] x_shift;
  logic        rst_col_det;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump,
    output col_detected, outbounds, game_win,
    input  blkpos_x, blkpos_y, x_shift, rst_col_det
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump,
    input  col_detected, outbounds, game_win,
    output blkpos_x, blkpos_y, x_shift, rst_col_det
  );
endinterface
`default_nettype wire

// File: rtl/player_motion_ctrl_btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync
// Brief    : Two-flop synchroniser for an asynchronous push button, plus a
//            one-cycle pulse on the synchronised rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  // [0],[1] form the synchroniser; [2] holds the previous synced level.
  logic [2:0] sync_q;

  // Shift the raw button through the synchroniser and edge history.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], btn_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_motion_ctrl
// Brief    : Per-frame player physics and map scroll. Alternates X and Y move
//            frames so a collision reported by the renderer maps to one axis.
//            Build option: define AIR_JUMP_EN to allow one extra mid-air jump.
// Revision : 1.0 - initial release
// ============================================================================
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int SPEED     = 4,
  parameter int GRAV      = 1,
  parameter int JUMP_V    = 20,
  parameter int VMAX      = 12,
  parameter int SCROLL_X  = 672,
  parameter int MAX_SHIFT = 3360,
  parameter int SPAWN_X   = 96,
  parameter int SPAWN_Y   = 720
) (
  input logic                 clk,
  input logic                 rst,
  player_motion_ctrl_if.slave bus
);
  localparam logic [10:0]       C_SPAWN_X = 11'(SPAWN_X);
  localparam logic [9:0]        C_SPAWN_Y = 10'(SPAWN_Y);
  localparam logic [11:0]       C_SPEED   = 12'(SPEED);
  localparam logic [11:0]       C_XMAX    = 12'(SCREEN_W - PLAYER_SZ);
  localparam logic [11:0]       C_SCROLL  = 12'(SCROLL_X);
  localparam logic [11:0]       C_MAXSH   = 12'(MAX_SHIFT);
  localparam logic signed [7:0] C_GRAV    = 8'(GRAV);
  localparam logic signed [7:0] C_VMAX    = 8'(VMAX);
  localparam logic signed [7:0] C_JUMP    = 8'(-JUMP_V);

  state_t state_q, state_d;
  phase_t phase_q;
  logic [10:0] pos_x_q, safe_x_q, move_x_d;
  logic [9:0]  pos_y_q, safe_y_q, move_y_d;
  logic [11:0] shift_q, safe_s_q, move_s_d, x_sum;
  logic signed [7:0]  vy_q, move_vy_d, vy_new;
  logic signed [10:0] y_sum;
  logic grounded_q, move_grounded_d, last_y_q, jump_req_q, jump_now;
  logic rst_col_det_q, rst_col_det_d;
  logic [1:0] tick_sr_q;
`ifdef AIR_JUMP_EN
  logic air_armed_q, move_air_d;
`endif

  // Button synchronisers: [0]=left, [1]=right, [2]=jump.
  logic [2:0] btn_raw, btn_level, btn_rise;
  assign btn_raw = {bus.btn_jump, bus.btn_right, bus.btn_left};
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_sync u_sync (.clk(clk), .rst(rst), .btn_i(btn_raw[gi]),
                     .level_o(btn_level[gi]), .rise_o(btn_rise[gi]));
  end
  // Only the jump button is edge-triggered; left/right act on level.
  logic unused_rise;
  assign unused_rise = &{1'b0, btn_rise[1:0]};

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  // Next state; rst_col_det fires in ACK, or tick+3 while frozen in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:    if (bus.frame_tick) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = bus.game_win ? ST_DONE : ST_MOVE;
      ST_MOVE:    state_d = ST_ACK;
      ST_ACK:     state_d = ST_WAIT;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_WAIT;
    endcase
    rst_col_det_d = (state_d == ST_ACK) || ((state_q == ST_DONE) && tick_sr_q[1]);
  end

  // Candidate positions/velocity for this frame's MOVE step.
  always_comb begin
    move_x_d        = pos_x_q;
    move_s_d        = shift_q;
    move_y_d        = pos_y_q;
    move_vy_d       = vy_q;
    move_grounded_d = grounded_q;
`ifdef AIR_JUMP_EN
    move_air_d      = air_armed_q;
`endif
    x_sum    = {1'b0, pos_x_q} + C_SPEED;
    jump_now = jump_req_q | btn_rise[2];
    vy_new   = vy_q;
    // Horizontal: scroll the map once the player is past the scroll line.
    if (btn_level[1] && !btn_level[0]) begin
      if (({1'b0, pos_x_q} >= C_SCROLL) && ((shift_q + C_SPEED) <= C_MAXSH))
        move_s_d = shift_q + C_SPEED;
      else if (x_sum > C_XMAX)
        move_x_d = C_XMAX[10:0];
      else
        move_x_d = x_sum[10:0];
    end else if (btn_level[0] && !btn_level[1]) begin
      if ({1'b0, pos_x_q} < C_SPEED) move_x_d = '0;
      else                           move_x_d = pos_x_q - C_SPEED[10:0];
    end
    // Vertical: a grounded player keeps getting gravity so the next
    // collision re-confirms the ground contact.
    if (jump_now && grounded_q) begin
      vy_new          = C_JUMP;
      move_grounded_d = 1'b0;
    end
`ifdef AIR_JUMP_EN
    else if (jump_now && air_armed_q) begin
      vy_new     = C_JUMP;
      move_air_d = 1'b0;
    end
`endif
    else if (vy_q >= (C_VMAX - C_GRAV)) vy_new = C_VMAX;
    else                                vy_new = vy_q + C_GRAV;
    y_sum = $signed({1'b0, pos_y_q}) + $signed({{3{vy_new[7]}}, vy_new});
    if (y_sum[10]) begin
      move_y_d  = '0;
      move_vy_d = '0;
    end else begin
      move_y_d  = y_sum[9:0];
      move_vy_d = vy_new;
    end
  end

  // Frame datapath: resolve last frame's renderer flags, then move one axis.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q <= C_SPAWN_X;  pos_y_q <= C_SPAWN_Y;  shift_q <= '0;
      safe_x_q <= C_SPAWN_X; safe_y_q <= C_SPAWN_Y; safe_s_q <= '0;
      vy_q <= '0; grounded_q <= 1'b0; phase_q <= PH_X; last_y_q <= 1'b0;
      jump_req_q <= 1'b0; tick_sr_q <= '0; rst_col_det_q <= 1'b0;
`ifdef AIR_JUMP_EN
      air_armed_q <= 1'b1;
`endif
    end else begin
      tick_sr_q     <= {tick_sr_q[0], bus.frame_tick};
      rst_col_det_q <= rst_col_det_d;
      if (btn_rise[2]) jump_req_q <= 1'b1;
      case (state_q)
        ST_RESOLVE: begin
          if (!bus.game_win) begin
            if (bus.outbounds) begin
              pos_x_q <= C_SPAWN_X;  pos_y_q <= C_SPAWN_Y;  shift_q <= '0;
              safe_x_q <= C_SPAWN_X; safe_y_q <= C_SPAWN_Y; safe_s_q <= '0;
              vy_q <= '0; grounded_q <= 1'b0; phase_q <= PH_X; last_y_q <= 1'b0;
`ifdef AIR_JUMP_EN
              air_armed_q <= 1'b1;
`endif
            end else if (bus.col_detected) begin
              pos_x_q <= safe_x_q; pos_y_q <= safe_y_q; shift_q <= safe_s_q;
              if (last_y_q) begin
                // Falling into something is a landing; rising is a head bump.
                if (!vy_q[7]) begin
                  grounded_q <= 1'b1;
`ifdef AIR_JUMP_EN
                  air_armed_q <= 1'b1;
`endif
                end
                vy_q <= '0;
              end
            end else begin
              safe_x_q <= pos_x_q; safe_y_q <= pos_y_q; safe_s_q <= shift_q;
              if (last_y_q) grounded_q <= 1'b0;
            end
          end
        end
        ST_MOVE: begin
          phase_q  <= (phase_q == PH_X) ? PH_Y : PH_X;
          last_y_q <= (phase_q == PH_Y);
          if (phase_q == PH_X) begin
            pos_x_q <= move_x_d;
            shift_q <= move_s_d;
          end else begin
            pos_y_q    <= move_y_d;
            vy_q       <= move_vy_d;
            grounded_q <= move_grounded_d;
            jump_req_q <= 1'b0;
`ifdef AIR_JUMP_EN
            air_armed_q <= move_air_d;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.blkpos_x    = pos_x_q;
  assign bus.blkpos_y    = pos_y_q;
  assign bus.x_shift     = shift_q;
  assign bus.rst_col_det = rst_col_det_q;
endmodule
`default_nettype wire
